// File: rtl/uart_alu_ctrl_pkg.sv
// uart_alu_ctrl_pkg: state encoding, default widths and ALU opcode constants
package uart_alu_ctrl_pkg;
  localparam int SIZEDATA_DEF = 8;
  localparam int SIZEOP_DEF = 6;
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;
  function automatic logic is_busy(input state_e s);
    return s inside {EXEC, SEND, WAIT_TX};
  endfunction
endpackage

// File: rtl/uart_alu_ctrl_rx_timeout_counter.sv
// rx_timeout_counter: counts idle cycles while enabled, pulses expire at TIMEOUT_CYCLES-1
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (clr_i || !en_i) ? '0 : cnt_q + 1'b1;
  assign expire_o = en_i && !clr_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
  // idle-cycle counter, held at zero when disabled so every entry starts fresh
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: routes RX bytes A, B, opcode to the ALU and the result to TX; optional RX_TIMEOUT_EN inter-byte timeout
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int SIZEDATA = SIZEDATA_DEF,
  parameter int SIZEOP = SIZEOP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_alu_result,
  input  logic                i_tx_done,
  output logic [SIZEDATA-1:0] o_alu_datoa,
  output logic [SIZEDATA-1:0] o_alu_datob,
  output logic [SIZEOP-1:0]   o_alu_opcode,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy
);
  state_e state_q, state_d;
  logic [SIZEDATA-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [SIZEOP-1:0] op_q, op_d;
  logic start_q, start_d;
  logic timeout;
`ifdef RX_TIMEOUT_EN
  rx_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .en_i     (state_q == WAIT_B || state_q == WAIT_OP),
    .clr_i    (i_rx_done),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  // next state and capture logic; a byte arriving with the timeout wins over it
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    tx_d = tx_q;
    start_d = state_q == EXEC;
    case (state_q)
      WAIT_A: begin
        a_d = i_rx_done ? i_rx_data : a_q;
        state_d = i_rx_done ? WAIT_B : WAIT_A;
      end
      WAIT_B: begin
        b_d = i_rx_done ? i_rx_data : b_q;
        state_d = i_rx_done ? WAIT_OP : (timeout ? WAIT_A : WAIT_B);
      end
      WAIT_OP: begin
        op_d = i_rx_done ? i_rx_data[SIZEOP-1:0] : op_q;
        state_d = i_rx_done ? EXEC : (timeout ? WAIT_A : WAIT_OP);
      end
      EXEC: begin
        tx_d = i_alu_result;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: state_d = i_tx_done ? WAIT_A : WAIT_TX;
      default: state_d = WAIT_A;
    endcase
  end
  // state and output registers; reset discards any partial command
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= WAIT_A;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      tx_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tx_q <= tx_d;
      start_q <= start_d;
    end
  end
  assign o_alu_datoa = a_q;
  assign o_alu_datob = b_q;
  assign o_alu_opcode = op_q;
  assign o_tx_data = tx_q;
  assign o_tx_start = start_q;
  assign o_busy = is_busy(state_q);
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: scoreboard bench for uart_alu_ctrl with directed commands
module tb_uart_alu_ctrl;
  import uart_alu_ctrl_pkg::*;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, alu_result;
  logic rx_done = 0, tx_done = 0;
  logic [7:0] datoa, datob, tx_data;
  logic [5:0] opcode;
  logic tx_start, busy;
  int checks = 0, errs = 0, cyc = 0, starts = 0, exp_starts = 0;
  typedef struct {
    logic [7:0] a, b, res;
    logic [5:0] op;
    int c;
  } exp_t;
  exp_t sb[$];

  uart_alu_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_alu_result(alu_result), .i_tx_done(tx_done), .o_alu_datoa(datoa),
    .o_alu_datob(datob), .o_alu_opcode(opcode), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (opcode)
      OP_ADD: alu_result = datoa + datob;
      OP_SUB: alu_result = datoa - datob;
      OP_AND: alu_result = datoa & datob;
      OP_OR:  alu_result = datoa | datob;
      OP_XOR: alu_result = datoa ^ datob;
      OP_SRA: alu_result = $signed(datoa) >>> datob;
      OP_SRL: alu_result = datoa >> datob;
      OP_NOR: alu_result = ~(datoa | datob);
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      exp_t e;
      starts++;
      if (sb.size() == 0) chk("unexpected_tx_start", 1, 0);
      else begin
        e = sb.pop_front();
        chk("datoa", datoa, e.a);
        chk("datob", datob, e.b);
        chk("opcode", opcode, e.op);
        chk("tx_data", tx_data, e.res);
        chk("start_cycle", cyc, e.c);
        chk("busy_at_start", busy, 1);
      end
    end
  end

  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1;
    @(negedge clk);
    rx_done = 0;
  endtask

  task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] res);
    exp_t e;
    rx(a);
    rx(b);
    @(negedge clk);
    e.a = a; e.b = b; e.op = op[5:0]; e.res = res; e.c = cyc + 2;
    sb.push_back(e);
    exp_starts++;
    rx_data = op;
    rx_done = 1;
    @(negedge clk);
    rx_done = 0;
  endtask

  task automatic wait_wait_tx;
    int n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("tx_start_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic finish_tx;
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_datoa"}, datoa, 0);
    chk({tag, "_datob"}, datob, 0);
    chk({tag, "_opcode"}, opcode, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk_zero("reset");
    // tx_done outside WAIT_TX is ignored
    finish_tx();
    chk("txdone_idle_busy", busy, 0);
    cmd(8'h05, 8'h03, 8'h20, 8'h08);
    wait_wait_tx();
    repeat (3) @(negedge clk);
    chk("busy_in_wait_tx", busy, 1);
    finish_tx();
    chk("busy_after_tx_done", busy, 0);
    cmd(8'h0C, 8'h0A, 8'hE2, 8'h02);
    wait_wait_tx();
    finish_tx();
    cmd(8'h0F, 8'h33, 8'h25, 8'h3F);
    wait_wait_tx();
    rx(8'hAA);
    finish_tx();
    @(negedge clk);
    chk("dropped_byte_datoa", datoa, 8'h0F);
    cmd(8'h01, 8'h02, 8'h24, 8'h00);
    wait_wait_tx();
    finish_tx();
    cmd(8'hF0, 8'h0F, 8'h26, 8'hFF);
    wait_wait_tx();
    rx_data = 8'h77;
    rx_done = 1;
    tx_done = 1;
    @(negedge clk);
    rx_done = 0;
    tx_done = 0;
    chk("simul_busy", busy, 0);
    chk("simul_datoa", datoa, 8'hF0);
    cmd(8'h80, 8'h02, 8'h03, 8'hE0);
    wait_wait_tx();
    finish_tx();
    rx(8'h10);
    rx(8'h20);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_zero("midreset");
    cmd(8'h01, 8'h01, 8'h20, 8'h02);
    wait_wait_tx();
    finish_tx();
`ifdef RX_TIMEOUT_EN
    rx(8'h09);
    repeat (20) @(negedge clk);
    chk("timeout_busy", busy, 0);
    cmd(8'h04, 8'h05, 8'h20, 8'h09);
    wait_wait_tx();
    finish_tx();
`endif
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("start_count", starts, exp_starts);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
